rkv_bus_arbiter: RTL
====================

RKV_BUS_ARBITER -- requirements
Module: rkv_bus_arbiter

Interface
REQ-001 Parameter MASTER_NUM, default 2, number of upstream master ports (1..8).
REQ-002 Parameter SLAVE_NUM, default 2, number of downstream slave ports (1..16).
REQ-003 Parameter ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-004 Parameter TIMEOUT_CYC, default 16, slave-ack timeout in cycles (used only with REQ-029).
REQ-005 clk  input  1  single clock, all logic rising-edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 m_req  input  MASTER_NUM  per-master request; held with payload until the matching m_gnt.
REQ-008 m_write  input  MASTER_NUM  1 = write, 0 = read.
REQ-009 m_addr  input  MASTER_NUM*ADDR_W  packed per-master address; m_wdata  input  MASTER_NUM*DATA_W  write data.
REQ-010 m_gnt  output  MASTER_NUM  one-cycle one-hot grant pulse.
REQ-011 m_rvalid  output  MASTER_NUM  one-cycle one-hot completion pulse; m_rdata  output  DATA_W  read data; m_err  output  1  error flag, valid with m_rvalid.
REQ-012 s_req  output  SLAVE_NUM  one-hot slave request, held until s_ack; s_write  output  1; s_addr  output  ADDR_W; s_wdata  output  DATA_W.
REQ-013 s_ack  input  SLAVE_NUM  slave completion; s_rdata  input  SLAVE_NUM*DATA_W  packed read data, valid with s_ack.

Function
REQ-014 FSM states IDLE, GRANT, SLV, RESP; one transaction outstanding at a time.
REQ-015 IDLE: if any m_req is high, select the winner round-robin, starting the search at rr_ptr; latch index, write, addr and wdata; go to GRANT.
REQ-016 GRANT (1 cycle): m_gnt[winner]=1; decode slave index = addr[ADDR_W-1 -: 4].
REQ-017 GRANT, index < SLAVE_NUM: go to SLV. Index >= SLAVE_NUM: go to RESP with m_err=1 and m_rdata=0; no s_req is issued.
REQ-018 SLV: s_req[index]=1 with s_addr/s_write/s_wdata stable; on s_ack[index]=1, capture s_rdata slice (0 for writes) and go to RESP.
REQ-019 s_ack bits other than s_ack[index], and any s_ack outside SLV, are ignored.
REQ-020 RESP (1 cycle): m_rvalid[winner]=1, m_rdata = captured data, m_err as decided; then go to IDLE.
REQ-021 Best-case latency from m_req high in IDLE: m_gnt at +1 cycle, s_req at +2, m_rvalid at the cycle after s_ack.
REQ-022 rr_ptr updates to winner+1 (mod MASTER_NUM, wrapping from MASTER_NUM-1 to 0) in the GRANT cycle.
REQ-023 Requests arriving outside IDLE wait; simultaneous requests are served one per transaction in round-robin order.
REQ-024 Outputs are registered; m_gnt, m_rvalid and s_req are each at most one-hot.

Reset
REQ-025 rstn low asynchronously forces state=IDLE, rr_ptr=0, and all outputs to 0, including m_gnt, m_rvalid, m_rdata, m_err, s_req, s_write, s_addr and s_wdata.
REQ-026 Reset mid-transaction abandons the transaction; no m_rvalid is produced for it after reset release.
REQ-027 First arbitration after reset release favours master 0.

Configuration
REQ-028 Macro RKV_BUS_ARB_TIMEOUT_EN controls the timeout feature.
REQ-029 With RKV_BUS_ARB_TIMEOUT_EN defined: a counter cleared on entry to SLV increments each SLV cycle; if it reaches TIMEOUT_CYC without s_ack, drop s_req and go to RESP with m_err=1, m_rdata=0.
REQ-030 Without RKV_BUS_ARB_TIMEOUT_EN: no counter is present, and SLV waits indefinitely for s_ack.

Structure
REQ-031 Package rkv_bus_pkg holds the FSM state enum, the slave-select field width (4), and the error data constant (0).
REQ-032 Sub-module rkv_rr_arbiter (request vector + rr_ptr in, one-hot winner + index out, purely combinational) is instantiated once.

Verification
REQ-033 Single read: m_req[0], addr=0x0000_0010; slave0 acks 3 cycles after s_req with rdata 0xA5A5 -> m_gnt[0] at +1, s_req[0] at +2, m_rvalid[0] with m_rdata=0xA5A5, m_err=0.
REQ-034 Fairness: m_req=2'b11 held continuously for 4 transactions, immediate acks -> grant order 0,1,0,1.
REQ-035 Decode error: m_req[1], addr=0xF000_0000 (index 15) -> m_gnt[1], no s_req, then m_rvalid[1] with m_err=1 and m_rdata=0.
REQ-036 Write to slave1: addr=0x1000_0004, wdata=0x1234 -> s_req[1], s_write=1, s_wdata=0x1234; after ack, m_rvalid with m_rdata=0.
REQ-037 Reset in SLV: rstn low 2 cycles while s_req[0] is high -> all outputs 0 immediately, no m_rvalid afterwards, next grant goes to master 0.
REQ-038 Timeout (macro defined, TIMEOUT_CYC=16): slave never acks -> s_req drops after 16 SLV cycles and m_rvalid carries m_err=1.

Source files
------------

// File: rtl/rkv_bus_pkg.sv
// rtl/rkv_bus_pkg.sv - shared types and constants for the rkv bus arbiter
//
// Contents:
//   arb_state_e  transaction FSM states (IDLE, GRANT, SLV, RESP)
//   SLV_SEL_W    width of the slave-select field at the top of the address
//   ERR_RDATA    read data returned with an error response
//   idx_w()      index width for an N-entry one-hot vector (minimum 1)

package rkv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SLV   = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int SLV_SEL_W = 4;

    localparam int unsigned ERR_RDATA = 0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rkv_rr_arbiter.sv
// rtl/rkv_rr_arbiter.sv - combinational round-robin request selector
//
// Ports:
//   req_i  [N-1:0]      request vector
//   ptr_i  [IDX_W-1:0]  first index to consider (round-robin pointer)
//   gnt_o  [N-1:0]      one-hot winner, all zero when no request
//   idx_o  [IDX_W-1:0]  binary index of the winner, zero when no request

module rkv_rr_arbiter
    import rkv_bus_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;
    logic           found;
    logic           cand_req;

    // Walk the candidates ptr, ptr+1, ... (mod N); first requester wins.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        cand_req = 1'b0;
        for (int off = 0; off < N; off++) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(off);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            cand_req = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (cand[IDX_W-1:0] == IDX_W'(i)) begin
                    cand_req = req_i[i];
                end
            end
            if (!found && cand_req) begin
                found = 1'b1;
                idx_o = cand[IDX_W-1:0];
                for (int i = 0; i < N; i++) begin
                    gnt_o[i] = (cand[IDX_W-1:0] == IDX_W'(i));
                end
            end
        end
    end

endmodule

// File: rtl/rkv_bus_arbiter.sv
// rtl/rkv_bus_arbiter.sv - N-master to M-slave bus arbiter, one transaction at a time
//
// Optional feature macro: RKV_BUS_ARB_TIMEOUT_EN (slave-ack timeout of TIMEOUT_CYC cycles)
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   m_req/m_write/m_addr/m_wdata   per-master request and payload (packed)
//   m_gnt                     one-cycle one-hot grant
//   m_rvalid/m_rdata/m_err    one-cycle one-hot completion with data and error flag
//   s_req/s_write/s_addr/s_wdata   one-hot slave request and payload, held until ack
//   s_ack/s_rdata             per-slave completion and packed read data

module rkv_bus_arbiter
    import rkv_bus_pkg::*;
#(
    parameter int MASTER_NUM  = 2,
    parameter int SLAVE_NUM   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [MASTER_NUM-1:0]        m_req,
    input  logic [MASTER_NUM-1:0]        m_write,
    input  logic [MASTER_NUM*ADDR_W-1:0] m_addr,
    input  logic [MASTER_NUM*DATA_W-1:0] m_wdata,
    output logic [MASTER_NUM-1:0]        m_gnt,
    output logic [MASTER_NUM-1:0]        m_rvalid,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic [SLAVE_NUM-1:0]         s_req,
    output logic                         s_write,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [SLAVE_NUM-1:0]         s_ack,
    input  logic [SLAVE_NUM*DATA_W-1:0]  s_rdata
);

    localparam int                 MIDX_W      = idx_w(MASTER_NUM);
    localparam logic [SLV_SEL_W:0] SLAVE_NUM_L = (SLV_SEL_W + 1)'(SLAVE_NUM);

    arb_state_e state_q, state_d;

    logic [MIDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [MIDX_W-1:0] midx_q, midx_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [MASTER_NUM-1:0] m_gnt_q, m_gnt_d;
    logic [MASTER_NUM-1:0] m_rvalid_q, m_rvalid_d;
    logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;
    logic                  m_err_q, m_err_d;
    logic [SLAVE_NUM-1:0]  s_req_q, s_req_d;
    logic                  s_write_q, s_write_d;
    logic [ADDR_W-1:0]     s_addr_q, s_addr_d;
    logic [DATA_W-1:0]     s_wdata_q, s_wdata_d;

    logic [MASTER_NUM-1:0] win_oh;
    logic [MIDX_W-1:0]     win_idx;
    logic                  win_write;
    logic [ADDR_W-1:0]     win_addr;
    logic [DATA_W-1:0]     win_wdata;

    logic [SLV_SEL_W-1:0]  sidx_q, sidx_d;
    logic                  dec_ok;
    logic                  sel_ack;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  tmo_hit;

    rkv_rr_arbiter #(
        .N (MASTER_NUM)
    ) u_rr (
        .req_i (m_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx)
    );

    // Payload of the arbitration winner.
    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (win_oh[i]) begin
                win_write = m_write[i];
                win_addr  = m_addr[i*ADDR_W +: ADDR_W];
                win_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sidx_q = addr_q[ADDR_W-1 -: SLV_SEL_W];
    assign sidx_d = addr_d[ADDR_W-1 -: SLV_SEL_W];
    assign dec_ok = ({1'b0, sidx_q} < SLAVE_NUM_L);

    // Only the addressed slave's ack and data are looked at.
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (sidx_q == SLV_SEL_W'(i)) begin
                sel_ack   = s_ack[i];
                sel_rdata = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RKV_BUS_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Zero outside SLV so every SLV visit starts counting from 0.
    always_comb begin
        tmo_d = (state_q == ST_SLV) ? tmo_q + TMO_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // Fires in the TIMEOUT_CYC-th SLV cycle, so s_req is held that many cycles.
    assign tmo_hit = (state_q == ST_SLV) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            midx_q   <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            midx_q   <= midx_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        midx_d   = midx_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_req) begin
                    state_d = ST_GRANT;
                    midx_d  = win_idx;
                    write_d = win_write;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                end
            end
            ST_GRANT: begin
                rr_ptr_d = (midx_q == MIDX_W'(MASTER_NUM - 1)) ? '0 : midx_q + MIDX_W'(1);
                state_d  = dec_ok ? ST_SLV : ST_RESP;
            end
            ST_SLV: begin
                if (sel_ack || tmo_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output registers are loaded from the next state so each output is
    // valid during the cycle its state is occupied.
    always_comb begin
        m_gnt_d    = '0;
        m_rvalid_d = '0;
        m_rdata_d  = '0;
        m_err_d    = 1'b0;
        s_req_d    = '0;
        s_write_d  = 1'b0;
        s_addr_d   = '0;
        s_wdata_d  = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            m_gnt_d[i]    = (state_d == ST_GRANT) && (midx_d == MIDX_W'(i));
            m_rvalid_d[i] = (state_d == ST_RESP)  && (midx_d == MIDX_W'(i));
        end
        if (state_d == ST_SLV) begin
            for (int i = 0; i < SLAVE_NUM; i++) begin
                s_req_d[i] = (sidx_d == SLV_SEL_W'(i));
            end
            s_write_d = write_d;
            s_addr_d  = addr_d;
            s_wdata_d = wdata_d;
        end
        // Only an acked slave cycle gives a clean response; decode miss
        // (from GRANT) and timeout (SLV without ack) both report an error.
        if (state_d == ST_RESP) begin
            if ((state_q == ST_SLV) && sel_ack) begin
                m_err_d   = 1'b0;
                m_rdata_d = write_q ? '0 : sel_rdata;
            end else begin
                m_err_d   = 1'b1;
                m_rdata_d = DATA_W'(ERR_RDATA);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_gnt_q    <= '0;
            m_rvalid_q <= '0;
            m_rdata_q  <= '0;
            m_err_q    <= 1'b0;
            s_req_q    <= '0;
            s_write_q  <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
        end else begin
            m_gnt_q    <= m_gnt_d;
            m_rvalid_q <= m_rvalid_d;
            m_rdata_q  <= m_rdata_d;
            m_err_q    <= m_err_d;
            s_req_q    <= s_req_d;
            s_write_q  <= s_write_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
        end
    end

    assign m_gnt    = m_gnt_q;
    assign m_rvalid = m_rvalid_q;
    assign m_rdata  = m_rdata_q;
    assign m_err    = m_err_q;
    assign s_req    = s_req_q;
    assign s_write  = s_write_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;

endmodule
